// File: rtl/mcdf_arbiter_if.sv
// Arbiter-to-formatter word bus: registered word, source id and packet
// framing flowing downstream, ready flowing back upstream.
interface mcdf_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              a2f_val;
    logic [DATA_W-1:0] a2f_data;
    logic [1:0]        a2f_id;
    logic              a2f_sop;
    logic              a2f_eop;
    logic              f2a_rdy;

    // Arbiter side drives the word, formatter side drives ready.
    modport master (
        output a2f_val, a2f_data, a2f_id, a2f_sop, a2f_eop,
        input  f2a_rdy
    );

    modport slave (
        input  a2f_val, a2f_data, a2f_id, a2f_sop, a2f_eop,
        output f2a_rdy
    );
endinterface

// File: rtl/mcdf_arbiter.sv
// MCDF packet arbiter: picks one of three channels by priority (lower
// value wins, ties round-robin), streams exactly one packet of the latched
// length through a one-deep registered output stage, then re-arbitrates.
module mcdf_arbiter #(
    parameter int DATA_W  = 32,
    parameter int AVAIL_W = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               slv0_en_i,
    input  logic               slv1_en_i,
    input  logic               slv2_en_i,
    input  logic [1:0]         slv0_prio_i,
    input  logic [1:0]         slv1_prio_i,
    input  logic [1:0]         slv2_prio_i,
    input  logic [2:0]         slv0_len_i,
    input  logic [2:0]         slv1_len_i,
    input  logic [2:0]         slv2_len_i,
    input  logic [AVAIL_W-1:0] slv0_avail_i,
    input  logic [AVAIL_W-1:0] slv1_avail_i,
    input  logic [AVAIL_W-1:0] slv2_avail_i,
    input  logic               slv0_val_i,
    input  logic               slv1_val_i,
    input  logic               slv2_val_i,
    input  logic [DATA_W-1:0]  slv0_data_i,
    input  logic [DATA_W-1:0]  slv1_data_i,
    input  logic [DATA_W-1:0]  slv2_data_i,
    output logic               slv0_ack_o,
    output logic               slv1_ack_o,
    output logic               slv2_ack_o,
    mcdf_arbiter_if.master     a2f_if,
    output logic               arb_busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Length code to index of the last word: 4, 8, 16, then 32 for all
    // larger codes.
    function automatic logic [4:0] len_to_last(input logic [2:0] code);
        case (code)
            3'd0:    return 5'd3;
            3'd1:    return 5'd7;
            3'd2:    return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

    // Channel index 'step' places after 'base', modulo 3.
    function automatic logic [1:0] rr_add(input logic [1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= 3) sum = sum - 3;
        return sum[1:0];
    endfunction

    logic [2:0]         en_w;
    logic [1:0]         prio_w  [3];
    logic [2:0]         len_w   [3];
    logic [AVAIL_W-1:0] avail_w [3];
    logic [2:0]         elig;

    assign en_w       = {slv2_en_i, slv1_en_i, slv0_en_i};
    assign prio_w[0]  = slv0_prio_i;
    assign prio_w[1]  = slv1_prio_i;
    assign prio_w[2]  = slv2_prio_i;
    assign len_w[0]   = slv0_len_i;
    assign len_w[1]   = slv1_len_i;
    assign len_w[2]   = slv2_len_i;
    assign avail_w[0] = slv0_avail_i;
    assign avail_w[1] = slv1_avail_i;
    assign avail_w[2] = slv2_avail_i;

    logic [0:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [4:0]        last_q,  last_d;
    logic [4:0]        cnt_q,   cnt_d;
    logic [1:0]        rr_q,    rr_d;
    logic              val_q,   val_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [1:0]        id_q,    id_d;
    logic              sop_q,   sop_d;
    logic              eop_q,   eop_d;

    logic              pick_found;
    logic [1:0]        pick_id;
    logic [1:0]        pick_prio;
    logic [1:0]        cand;
    logic              sel_val;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;

    // A channel is eligible when enabled and holding a whole packet.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            elig[n] = en_w[n] && (int'(avail_w[n]) > int'(len_to_last(len_w[n])));
        end
    end

    // Scan in round-robin order from rr_q; a strictly lower prio value
    // replaces the pick, so among equals the earliest in that order wins.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default before
        // any branch, otherwise a missed path would infer a latch.
        pick_found = 1'b0;
        pick_id    = 2'd0;
        pick_prio  = 2'd3;
        cand       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = rr_add(rr_q, k);
            if (elig[cand] && (!pick_found || (prio_w[cand] < pick_prio))) begin
                pick_found = 1'b1;
                pick_id    = cand;
                pick_prio  = prio_w[cand];
            end
        end
    end

    // Head word of the granted channel.
    always_comb begin
        sel_val  = 1'b0;
        sel_data = '0;
        case (grant_q)
            2'd0:    begin sel_val = slv0_val_i; sel_data = slv0_data_i; end
            2'd1:    begin sel_val = slv1_val_i; sel_data = slv1_data_i; end
            2'd2:    begin sel_val = slv2_val_i; sel_data = slv2_data_i; end
            default: begin sel_val = 1'b0;       sel_data = '0;          end
        endcase
    end

    // A word moves when the head is valid and the output slot is free or
    // draining this cycle.
    assign xfer       = (state_q == ST_XFER) && sel_val && (!val_q || a2f_if.f2a_rdy);
    assign slv0_ack_o = xfer && (grant_q == 2'd0);
    assign slv1_ack_o = xfer && (grant_q == 2'd1);
    assign slv2_ack_o = xfer && (grant_q == 2'd2);

    // Next-state: grant latch in IDLE, word counting in XFER, output slot.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        val_d   = val_q;
        data_d  = data_q;
        id_d    = id_q;
        sop_d   = sop_q;
        eop_d   = eop_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_XFER;
                    grant_d = pick_id;
                    last_d  = len_to_last(len_w[pick_id]);
                    cnt_d   = 5'd0;
                end
            end
            ST_XFER: begin
                if (xfer) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == last_q) begin
                        state_d = ST_IDLE;
                        rr_d    = rr_add(grant_q, 1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            val_d  = 1'b1;
            data_d = sel_data;
            id_d   = grant_q;
            sop_d  = (cnt_q == 5'd0);
            eop_d  = (cnt_q == last_q);
        end else if (a2f_if.f2a_rdy) begin
            val_d  = 1'b0;
        end
    end

    // State and output registers; reset abandons any partial packet.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: the data register is reset along with control so the
            // bus reads all-zero out of reset; it is a single word, not an
            // array, so the reset costs nothing meaningful.
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
            last_q  <= 5'd0;
            cnt_q   <= 5'd0;
            rr_q    <= 2'd0;
            val_q   <= 1'b0;
            data_q  <= '0;
            id_q    <= 2'd0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            val_q   <= val_d;
            data_q  <= data_d;
            id_q    <= id_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign a2f_if.a2f_val  = val_q;
    assign a2f_if.a2f_data = data_q;
    assign a2f_if.a2f_id   = id_q;
    assign a2f_if.a2f_sop  = sop_q;
    assign a2f_if.a2f_eop  = eop_q;
    assign arb_busy_o      = (state_q == ST_XFER);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Scoreboard bench for mcdf_arbiter: a packet-level model predicts every
// output word when a phase starts; a negedge monitor compares handshakes,
// ack rules and output stability under random ready/valid gaps.
module tb_mcdf_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  id;
        logic        sop;
        logic        eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  en;
    logic [1:0]  prio  [3];
    logic [2:0]  len   [3];
    logic [7:0]  avail [3];
    logic [2:0]  val;
    logic [31:0] data  [3];
    logic [2:0]  ack;
    logic        busy;

    mcdf_arbiter_if #(.DATA_W(32)) a2f_bus ();

    mcdf_arbiter #(.DATA_W(32), .AVAIL_W(8)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .slv0_en_i    (en[0]),
        .slv1_en_i    (en[1]),
        .slv2_en_i    (en[2]),
        .slv0_prio_i  (prio[0]),
        .slv1_prio_i  (prio[1]),
        .slv2_prio_i  (prio[2]),
        .slv0_len_i   (len[0]),
        .slv1_len_i   (len[1]),
        .slv2_len_i   (len[2]),
        .slv0_avail_i (avail[0]),
        .slv1_avail_i (avail[1]),
        .slv2_avail_i (avail[2]),
        .slv0_val_i   (val[0]),
        .slv1_val_i   (val[1]),
        .slv2_val_i   (val[2]),
        .slv0_data_i  (data[0]),
        .slv1_data_i  (data[1]),
        .slv2_data_i  (data[2]),
        .slv0_ack_o   (ack[0]),
        .slv1_ack_o   (ack[1]),
        .slv2_ack_o   (ack[2]),
        .a2f_if       (a2f_bus),
        .arb_busy_o   (busy)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          hs_cnt      = 0;
    int          mdl_rr      = 0;
    int          phase_id    = 0;
    logic [31:0] chq [3][$];
    exp_t        sb  [$];
    logic [2:0]  pop_pend    = '0;
    logic        prev_val    = 1'b0;
    logic        prev_rdy    = 1'b0;
    logic [35:0] prev_word   = '0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [35:0] cur_word();
        return {a2f_bus.a2f_data, a2f_bus.a2f_id, a2f_bus.a2f_sop, a2f_bus.a2f_eop};
    endfunction

    function automatic int words_of(input logic [2:0] code);
        return (code >= 3'd3) ? 32 : (4 << code);
    endfunction

    function automatic int rr_dist(input int n);
        return (n - mdl_rr + 3) % 3;
    endfunction

    // Packet-level reference: repeatedly grant the best eligible channel
    // from the current FIFO contents until nothing is eligible.
    task automatic build_expected(input logic [2:0] en_v);
        int   cnt [3];
        int   pos [3];
        int   best;
        int   w;
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            cnt[n] = chq[n].size();
            pos[n] = 0;
        end
        forever begin
            best = -1;
            for (int n = 0; n < 3; n++) begin
                if (en_v[n] && cnt[n] >= words_of(len[n])) begin
                    if (best < 0 || prio[n] < prio[best] ||
                        (prio[n] == prio[best] && rr_dist(n) < rr_dist(best)))
                        best = n;
                end
            end
            if (best < 0) break;
            w = words_of(len[best]);
            for (int i = 0; i < w; i++) begin
                e.data = chq[best][pos[best] + i];
                e.id   = 2'(best);
                e.sop  = (i == 0);
                e.eop  = (i == w - 1);
                sb.push_back(e);
            end
            pos[best] += w;
            cnt[best] -= w;
            mdl_rr = (best + 1) % 3;
        end
    endtask

    // Channel FIFO and formatter models: apply pops seen on ack, then
    // present new head words with random valid gaps and random ready.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int n = 0; n < 3; n++) begin
                if (pop_pend[n] && chq[n].size() > 0) void'(chq[n].pop_front());
                val[n]   = (chq[n].size() > 0) && ($urandom_range(0, 4) != 0);
                data[n]  = (chq[n].size() > 0) ? chq[n][0] : 32'd0;
                avail[n] = (chq[n].size() > 255) ? 8'd255 : 8'(chq[n].size());
            end
            a2f_bus.f2a_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: word handshakes against the scoreboard, hold-under-stall,
    // and ack legality.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_val <= 1'b0;
            pop_pend <= '0;
        end else begin
            pop_pend <= ack;
            if (prev_val && !prev_rdy)
                check({a2f_bus.a2f_val, cur_word()} == {1'b1, prev_word}, "hold_stable",
                      64'({a2f_bus.a2f_val, cur_word()}), 64'({1'b1, prev_word}));
            if (a2f_bus.a2f_val && a2f_bus.f2a_rdy) begin
                hs_cnt <= hs_cnt + 1;
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_word", 64'(cur_word()), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check(cur_word() == e, "word", 64'(cur_word()), 64'(e));
                end
            end
            if (ack != 3'b000) begin
                check(($countones(ack) == 1) && busy && !(a2f_bus.a2f_val && !a2f_bus.f2a_rdy),
                      "ack_rule", 64'({busy, a2f_bus.a2f_val, a2f_bus.f2a_rdy, ack}), 64'd0);
                if (sb.size() > 0)
                    check(ack == (3'b001 << sb[0].id), "ack_chan", 64'(ack), 64'(3'b001 << sb[0].id));
            end
            prev_val  <= a2f_bus.a2f_val;
            prev_rdy  <= a2f_bus.f2a_rdy;
            prev_word <= cur_word();
        end
    end

    task automatic load_phase(input logic [2:0] en_v, input logic [5:0] pr,
                              input logic [8:0] ln, input int c0, input int c1, input int c2);
        int c [3];
        c[0] = c0; c[1] = c1; c[2] = c2;
        phase_id++;
        @(posedge clk); #1;
        en = 3'b000;
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            chq[n].delete();
            for (int i = 0; i < c[n]; i++) chq[n].push_back({8'(n), 8'(phase_id), 16'(i)});
            prio[n] = pr[2*n +: 2];
            len[n]  = ln[3*n +: 3];
        end
        @(posedge clk);
        @(posedge clk); #1;
        build_expected(en_v);
        en = en_v;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check(cyc < 3000, "drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (4) @(posedge clk);
        check(busy == 1'b0 && sb.size() == 0, "idle_after_phase", 64'(busy), 64'd0);
    endtask

    task automatic run_phase(input logic [2:0] en_v, input logic [5:0] pr,
                             input logic [8:0] ln, input int c0, input int c1, input int c2);
        load_phase(en_v, pr, ln, c0, c1, c2);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        int cyc;
        int base;
        rstn = 1'b0;
        en   = 3'b000;
        for (int n = 0; n < 3; n++) begin
            prio[n] = 2'd0; len[n] = 3'd0; avail[n] = 8'd0; data[n] = 32'd0;
        end
        val = 3'b000;
        a2f_bus.f2a_rdy = 1'b0;

        #3;
        check(a2f_bus.a2f_val == 1'b0, "reset_val", 64'(a2f_bus.a2f_val), 64'd0);
        check(cur_word() == 36'd0, "reset_word", 64'(cur_word()), 64'd0);
        check(busy == 1'b0 && ack == 3'b000, "reset_busy_ack", 64'({busy, ack}), 64'd0);
        #20;
        @(negedge clk);
        rstn = 1'b1;

        // Round-robin from reset: order 0,1,2,0,1,2.
        run_phase(3'b111, 6'b01_01_01, 9'd0, 8, 8, 8);
        // Single channel 1, one 4-word packet.
        run_phase(3'b010, 6'd0, 9'd0, 0, 4, 0);
        // Priority: ch2 (prio 0) ahead of ch0 (prio 2).
        run_phase(3'b101, 6'b00_00_10, 9'd0, 4, 0, 4);
        // Backpressure case: two 8-word packets under random ready.
        run_phase(3'b011, 6'b00_00_00, 9'b000_001_001, 8, 8, 0);

        // Eligibility threshold and mid-packet config change.
        load_phase(3'b001, 6'd0, 9'b000_000_010, 15, 0, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check(seen == 0, "no_grant_at_15", 64'(seen), 64'd0);
        @(posedge clk); #1;
        chq[0].push_back(32'hE1E1_0010);
        build_expected(3'b001);
        cyc = 0;
        while (!busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(busy == 1'b1, "grant_at_16", 64'(busy), 64'd1);
        @(posedge clk); #1;
        en     = 3'b000;
        len[0] = 3'd0;
        prio[0] = 2'd3;
        wait_drain();

        // Random configurations.
        for (int p = 0; p < 12; p++) begin
            run_phase(3'($urandom_range(1, 7)), 6'($urandom), 9'($urandom),
                      $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
        end

        // Leave rr pointer at 2, then abort a packet with reset.
        run_phase(3'b010, 6'd0, 9'd0, 0, 4, 0);
        load_phase(3'b100, 6'd0, 9'b001_000_000, 0, 0, 8);
        base = hs_cnt;
        cyc  = 0;
        while (hs_cnt < base + 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check(cyc < 500, "reset_wait_timeout", 64'(hs_cnt - base), 64'd5);
        #1;
        rstn = 1'b0;
        #1;
        check(a2f_bus.a2f_val == 1'b0 && cur_word() == 36'd0, "reset_midpkt_out",
              64'({a2f_bus.a2f_val, cur_word()}), 64'd0);
        check(busy == 1'b0 && ack == 3'b000, "reset_midpkt_busy", 64'({busy, ack}), 64'd0);
        sb.delete();
        mdl_rr = 0;
        en = 3'b000;
        repeat (3) @(negedge clk);
        #3;
        rstn = 1'b1;
        // rr pointer back at 0 after reset: order 0,1,2.
        run_phase(3'b111, 6'b01_01_01, 9'd0, 4, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
